kernel_bank_db: RTL and testbench
=================================

Name: kernel_bank_db

Overview:
- Double-buffered, parametrised kernel weight store for the NPU convolution datapath. Generalises the single 3x3 serial-shift kernel register to KxK kernels of DATA_W bits.
- A shadow bank loads serially over a valid/ready stream while the active bank streams one kernel row per read to the MAC row.
- An atomic commit swaps the banks. An optional 180-degree flip, latched at commit, supports true convolution as well as correlation.

Parameters:
- DATA_W, 8, width of one kernel weight
- K, 3, kernel edge size (K>=2); the kernel holds K*K weights
- CNT_W, $clog2(K*K), width of the load counter (derived, do not override)
- ROW_W, $clog2(K), width of the row pointer (derived; minimum 1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  load_data holds a valid weight
- load_data  in  DATA_W  weight, row-major order, first word is element (0,0)
- load_ready  out  1  shadow bank can accept a weight
- shadow_full  out  1  shadow bank holds K*K weights, awaiting commit
- commit  in  1  request shadow/active swap
- flip_in  in  1  flip mode for the kernel being committed; sampled on an accepted commit
- commit_err  out  1  one-cycle pulse: commit while shadow not full
- active_valid  out  1  active bank holds a committed kernel
- rd_en  in  1  request next kernel row
- row_out  out  K*DATA_W  row weights; column c at [c*DATA_W +: DATA_W], column 0 in the LSBs
- row_idx  out  ROW_W  logical row index of row_out
- row_valid  out  1  row_out/row_idx valid this cycle

Behaviour:
- Reset (rst=1 at a clock edge) clears the following:
  - both banks to 0
  - wr_cnt=0, row_ptr=0, active bank select=0, flip=0
  - outputs: load_ready=1, shadow_full=0, commit_err=0, active_valid=0, row_out=0, row_idx=0, row_valid=0
  - rst mid-load or mid-read aborts the operation; no partial state survives.
- Loader, two states:
  - LOAD: load_ready=1. When load_valid&load_ready, write shadow[wr_cnt] and increment wr_cnt. The write with wr_cnt==K*K-1 moves to FULL.
  - FULL: load_ready=0, shadow_full=1. load_valid is ignored.
- Commit accepted (commit=1 and shadow_full=1):
  - next cycle: bank select toggles, active_valid=1, flip<=flip_in, row_ptr=0, wr_cnt=0, loader returns to LOAD (load_ready=1, shadow_full=0).
  - The old active bank becomes the new shadow and is overwritten by the next load.
- Commit rejected (commit=1 and shadow_full=0): commit_err=1 for one cycle; no other state changes.
- Read:
  - rd_en=1 with active_valid=1 produces, next cycle, row_valid=1, row_idx=row_ptr, and row_out = row row_ptr of the active bank. row_ptr then increments, wrapping K-1 to 0.
  - rd_en=0 or active_valid=0 gives row_valid=0 next cycle. row_out and row_idx hold their last values.
  - Latency is 1 cycle; throughput is 1 row per cycle.
- Flip (latched flip=1): output element (r,c) = stored[(K-1-r)*K + (K-1-c)]. flip=0 gives stored[r*K+c].
- Simultaneous events:
  - commit accepted + rd_en in the same cycle: the read is served from the pre-swap bank with the pre-swap flip and row_ptr. After the swap, row_ptr=0.
  - load and read in the same cycle are independent, since they use different banks.
  - commit accepted + load_valid in the same cycle: no write, because load_ready=0 in FULL.
  - rst has priority over everything.
- No arithmetic beyond counters. All counters wrap or saturate exactly as stated above, with no overflow paths.

Decomposition:
- Shared package npu_pkg holds:
  - DATA_W and K defaults
  - loader state enum {LD_LOAD, LD_FULL}
  - helper function flip_index(r,c,K)
- One natural sub-module: kernel_bank_mem, a single KxK register bank with a write port (index, data, we) and a combinational row read (row index, flip). It is instantiated twice; the top holds the loader FSM, commit logic and read pointer.

Test Plan:
- Load/read: after rst, stream weights 1..9 (K=3), commit with flip_in=0, then rd_en for 4 cycles. Expect rows {1,2,3},{4,5,6},{7,8,9},{1,2,3}, with row_idx 0,1,2,0 and 1-cycle latency. In the packed bus, col0 = 1 sits in the LSB byte.
- Flip: load 1..9, commit with flip_in=1, then read 3 rows. Expect {9,8,7},{6,5,4},{3,2,1}.
- Backpressure and error:
  - After 9 accepted words, load_ready=0 and shadow_full=1; a 10th load_valid is ignored.
  - commit after only 5 words gives a 1-cycle commit_err pulse, and active_valid is unchanged.
- Double buffering: with kernel A (1..9) active and reading continuously, load B (11..19) in parallel. Reads keep returning A until commit. Assert commit together with rd_en at row_ptr=1: that cycle returns A row 1, and the next read returns B row 0 {11,12,13}.
- Reset mid-operation: rst after 4 loaded words and during reads. Next cycle all outputs are 0, load_ready=1 and active_valid=0; a fresh 9-word load+commit then works normally.
- Parameter sweep: K=4, DATA_W=16, weights 0x100..0x10F. Row 3 is {0x10C..0x10F}; with flip, row 0 is {0x10F,0x10E,0x10D,0x10C}.

Source files
------------

// File: rtl/kernel_bank_db_pkg.sv
// Shared types and helpers for the double-buffered KxK kernel weight store.
// Holds default geometry, the loader state encoding and the flipped-index helper.
package kernel_bank_db_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int K_DEF      = 3;

  typedef enum logic {
    LD_LOAD = 1'b0,
    LD_FULL = 1'b1
  } ld_state_t;

  // Row-major position of element (r,c) after a 180-degree rotation of a KxK kernel.
  function automatic int flip_index(input int r, input int c, input int k);
    return (k - 1 - r) * k + (k - 1 - c);
  endfunction

endpackage

// File: rtl/kernel_bank_db_if.sv
// Load / commit / row-read bundle for kernel_bank_db; master drives requests, slave is the store.
// Load uses valid/ready, commit and rd_en are single-cycle strobes.
interface kernel_bank_db_if #(
  parameter int DATA_W = 8,
  parameter int K      = 3
);
  localparam int ROW_W = $clog2(K);

  logic                  load_valid;
  logic [DATA_W-1:0]     load_data;
  logic                  load_ready;
  logic                  shadow_full;
  logic                  commit;
  logic                  flip_in;
  logic                  commit_err;
  logic                  active_valid;
  logic                  rd_en;
  logic [K*DATA_W-1:0]   row_out;
  logic [ROW_W-1:0]      row_idx;
  logic                  row_valid;

  modport master (
    output load_valid, load_data, commit, flip_in, rd_en,
    input  load_ready, shadow_full, commit_err, active_valid, row_out, row_idx, row_valid
  );

  modport slave (
    input  load_valid, load_data, commit, flip_in, rd_en,
    output load_ready, shadow_full, commit_err, active_valid, row_out, row_idx, row_valid
  );

endinterface

// File: rtl/kernel_bank_mem.sv
// One KxK weight bank: registered write port, combinational row read with optional 180-degree flip.
// Write lands next cycle; read is zero-latency; no backpressure (caller owns write enable).
module kernel_bank_mem
  import kernel_bank_db_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = K_DEF,
  localparam int KK    = K * K,
  localparam int CNT_W = $clog2(KK),
  localparam int ROW_W = $clog2(K)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [CNT_W-1:0]    wr_idx,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [ROW_W-1:0]    rd_row,
  input  logic                rd_flip,
  output logic [K*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [KK];
  logic [DATA_W-1:0] mem_d [KK];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Column c of the row lands at [c*DATA_W +: DATA_W], column 0 in the LSBs.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < K; c++) begin
      if (rd_flip) begin
        rd_data[c*DATA_W +: DATA_W] = mem_q[CNT_W'(flip_index(int'(rd_row), c, K))];
      end else begin
        rd_data[c*DATA_W +: DATA_W] = mem_q[CNT_W'(int'(rd_row) * K + c)];
      end
    end
  end

endmodule

// File: rtl/kernel_bank_db.sv
// Double-buffered KxK kernel store: serial shadow load, atomic commit swap, 1-cycle row reads.
// load_ready drops once the shadow holds K*K weights until a commit frees it; reads never stall.
module kernel_bank_db
  import kernel_bank_db_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = K_DEF
) (
  input  logic           clk,
  input  logic           rst,
  kernel_bank_db_if.slave bus
);

  localparam int KK    = K * K;
  localparam int CNT_W = $clog2(KK);
  localparam int ROW_W = $clog2(K);

  ld_state_t             ld_state_q, ld_state_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic                  bank_sel_q, bank_sel_d;
  logic                  flip_q, flip_d;
  logic                  active_valid_q, active_valid_d;
  logic [ROW_W-1:0]      row_ptr_q, row_ptr_d;
  logic [K*DATA_W-1:0]   row_out_q, row_out_d;
  logic [ROW_W-1:0]      row_idx_q, row_idx_d;
  logic                  row_valid_q, row_valid_d;
  logic                  commit_err_q, commit_err_d;

  logic                  load_fire;
  logic                  rd_fire;
  logic [K*DATA_W-1:0]   bank0_row, bank1_row, active_row;

  assign load_fire  = bus.load_valid && (ld_state_q == LD_LOAD);
  assign rd_fire    = bus.rd_en && active_valid_q;
  assign active_row = bank_sel_q ? bank1_row : bank0_row;

  // The shadow is always the bank not selected as active.
  kernel_bank_mem #(.DATA_W(DATA_W), .K(K)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we      (load_fire && bank_sel_q),
    .wr_idx  (wr_cnt_q),
    .wr_data (bus.load_data),
    .rd_row  (row_ptr_q),
    .rd_flip (flip_q),
    .rd_data (bank0_row)
  );

  kernel_bank_mem #(.DATA_W(DATA_W), .K(K)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we      (load_fire && !bank_sel_q),
    .wr_idx  (wr_cnt_q),
    .wr_data (bus.load_data),
    .rd_row  (row_ptr_q),
    .rd_flip (flip_q),
    .rd_data (bank1_row)
  );

  always_comb begin
    ld_state_d     = ld_state_q;
    wr_cnt_d       = wr_cnt_q;
    bank_sel_d     = bank_sel_q;
    flip_d         = flip_q;
    active_valid_d = active_valid_q;
    row_ptr_d      = row_ptr_q;
    row_out_d      = row_out_q;
    row_idx_d      = row_idx_q;
    row_valid_d    = 1'b0;
    commit_err_d   = 1'b0;

    if (load_fire) begin
      if (wr_cnt_q == CNT_W'(KK - 1)) begin
        ld_state_d = LD_FULL;
        wr_cnt_d   = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end

    // A read in the commit cycle still sees the pre-swap bank, flip and pointer.
    if (rd_fire) begin
      row_valid_d = 1'b1;
      row_idx_d   = row_ptr_q;
      row_out_d   = active_row;
      row_ptr_d   = (row_ptr_q == ROW_W'(K - 1)) ? '0 : row_ptr_q + ROW_W'(1);
    end

    if (bus.commit) begin
      if (ld_state_q == LD_FULL) begin
        bank_sel_d     = ~bank_sel_q;
        active_valid_d = 1'b1;
        flip_d         = bus.flip_in;
        row_ptr_d      = '0;
        wr_cnt_d       = '0;
        ld_state_d     = LD_LOAD;
      end else begin
        commit_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state_q     <= LD_LOAD;
      wr_cnt_q       <= '0;
      bank_sel_q     <= 1'b0;
      flip_q         <= 1'b0;
      active_valid_q <= 1'b0;
      row_ptr_q      <= '0;
      row_out_q      <= '0;
      row_idx_q      <= '0;
      row_valid_q    <= 1'b0;
      commit_err_q   <= 1'b0;
    end else begin
      ld_state_q     <= ld_state_d;
      wr_cnt_q       <= wr_cnt_d;
      bank_sel_q     <= bank_sel_d;
      flip_q         <= flip_d;
      active_valid_q <= active_valid_d;
      row_ptr_q      <= row_ptr_d;
      row_out_q      <= row_out_d;
      row_idx_q      <= row_idx_d;
      row_valid_q    <= row_valid_d;
      commit_err_q   <= commit_err_d;
    end
  end

  assign bus.load_ready   = (ld_state_q == LD_LOAD);
  assign bus.shadow_full  = (ld_state_q == LD_FULL);
  assign bus.commit_err   = commit_err_q;
  assign bus.active_valid = active_valid_q;
  assign bus.row_out      = row_out_q;
  assign bus.row_idx      = row_idx_q;
  assign bus.row_valid    = row_valid_q;

endmodule

// File: tb/tb_kernel_bank_db.sv
// Bench for kernel_bank_db: K=3/8-bit instance against a queue-based kernel model, plus a K=4/16-bit instance.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_kernel_bank_db;

  localparam int K1 = 3, D1 = 8,  KK1 = 9;
  localparam int K2 = 4, D2 = 16, KK2 = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kernel_bank_db_if #(.DATA_W(D1), .K(K1)) a();
  kernel_bank_db_if #(.DATA_W(D2), .K(K2)) b();

  kernel_bank_db #(.DATA_W(D1), .K(K1)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  kernel_bank_db #(.DATA_W(D2), .K(K2)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Kernel-level model: shadow is a queue of accepted words, active is a snapshot array.
  logic [7:0]  m_shadow[$];
  logic [7:0]  m_act[KK1];
  logic        m_act_valid, m_flip, m_row_valid, m_err;
  int          m_rptr, m_row_idx;
  logic [23:0] m_row_out;

  function automatic logic [23:0] model_row(input int r);
    logic [23:0] v;
    v = '0;
    for (int c = 0; c < K1; c++) begin
      int lin;
      lin = r * K1 + c;
      v[c*8 +: 8] = m_flip ? m_act[KK1 - 1 - lin] : m_act[lin];
    end
    return v;
  endfunction

  task automatic model_reset();
    m_shadow.delete();
    for (int i = 0; i < KK1; i++) m_act[i] = 8'h00;
    m_act_valid = 1'b0; m_flip = 1'b0; m_row_valid = 1'b0; m_err = 1'b0;
    m_rptr = 0; m_row_idx = 0; m_row_out = '0;
  endtask

  task automatic model_step(input logic lv, input logic [7:0] ld, input logic cm,
                            input logic fi, input logic re);
    logic full;
    full  = (m_shadow.size() == KK1);
    m_err = cm && !full;
    if (re && m_act_valid) begin
      m_row_valid = 1'b1;
      m_row_out   = model_row(m_rptr);
      m_row_idx   = m_rptr;
      m_rptr      = (m_rptr + 1) % K1;
    end else begin
      m_row_valid = 1'b0;
    end
    if (lv && !full) m_shadow.push_back(ld);
    if (cm && full) begin
      for (int i = 0; i < KK1; i++) m_act[i] = m_shadow[i];
      m_shadow.delete();
      m_act_valid = 1'b1;
      m_flip      = fi;
      m_rptr      = 0;
    end
  endtask

  task automatic compare_all();
    check_eq("load_ready",   64'(a.load_ready),   64'(m_shadow.size() < KK1));
    check_eq("shadow_full",  64'(a.shadow_full),  64'(m_shadow.size() == KK1));
    check_eq("commit_err",   64'(a.commit_err),   64'(m_err));
    check_eq("active_valid", 64'(a.active_valid), 64'(m_act_valid));
    check_eq("row_valid",    64'(a.row_valid),    64'(m_row_valid));
    check_eq("row_out",      64'(a.row_out),      64'(m_row_out));
    check_eq("row_idx",      64'(a.row_idx),      64'(m_row_idx));
  endtask

  task automatic idle_inputs();
    a.load_valid = 1'b0; a.load_data = '0; a.commit = 1'b0; a.flip_in = 1'b0; a.rd_en = 1'b0;
    b.load_valid = 1'b0; b.load_data = '0; b.commit = 1'b0; b.flip_in = 1'b0; b.rd_en = 1'b0;
  endtask

  task automatic cyc(input logic lv, input logic [7:0] ld, input logic cm,
                     input logic fi, input logic re);
    @(negedge clk);
    a.load_valid = lv; a.load_data = ld; a.commit = cm; a.flip_in = fi; a.rd_en = re;
    @(posedge clk);
    model_step(lv, ld, cm, fi, re);
    #1 compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    model_reset();
    #1 compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cyc_b(input logic lv, input logic [15:0] ld, input logic cm,
                       input logic fi, input logic re);
    @(negedge clk);
    b.load_valid = lv; b.load_data = ld; b.commit = cm; b.flip_in = fi; b.rd_en = re;
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input int base, input logic fi);
    for (int i = 0; i < KK1; i++) cyc(1'b1, 8'(base + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, fi, 1'b0);
  endtask

  logic [23:0] exp_rows [4];
  logic [23:0] exp_flip [3];

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    exp_rows = '{24'h030201, 24'h060504, 24'h090807, 24'h030201};
    exp_flip = '{24'h070809, 24'h040506, 24'h010203};

    // Reset state
    do_reset();
    check_eq("rst_load_ready", 64'(a.load_ready), 64'd1);
    check_eq("rst_active_valid", 64'(a.active_valid), 64'd0);

    // Plain load/read, with a 10th word offered while full
    for (int i = 0; i < KK1; i++) cyc(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0);
    check_eq("bp_load_ready", 64'(a.load_ready), 64'd0);
    check_eq("bp_shadow_full", 64'(a.shadow_full), 64'd1);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("commit_active_valid", 64'(a.active_valid), 64'd1);
    for (int r = 0; r < 4; r++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check_eq("rd_row", 64'(a.row_out), 64'(exp_rows[r]));
      check_eq("rd_idx", 64'(a.row_idx), 64'(r % K1));
    end

    // Flipped kernel
    load_a(1, 1'b1);
    for (int r = 0; r < 3; r++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check_eq("flip_row", 64'(a.row_out), 64'(exp_flip[r]));
    end

    // Premature commit
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(40 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("err_pulse", 64'(a.commit_err), 64'd1);
    check_eq("err_active_kept", 64'(a.active_valid), 64'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("err_pulse_end", 64'(a.commit_err), 64'd0);

    // Reset during a partial load and active reads
    do_reset();
    check_eq("midrst_row_out", 64'(a.row_out), 64'd0);
    check_eq("midrst_load_ready", 64'(a.load_ready), 64'd1);
    check_eq("midrst_active_valid", 64'(a.active_valid), 64'd0);
    load_a(1, 1'b0);

    // Double buffering: read A while loading B, commit together with a read at row 1
    for (int i = 0; i < KK1; i++) cyc(1'b1, 8'(11 + i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < K1 && m_rptr != 1; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("db_rptr_reached", 64'(m_rptr), 64'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check_eq("db_commit_row", 64'(a.row_out), 64'h060504);
    check_eq("db_commit_idx", 64'(a.row_idx), 64'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("db_new_row", 64'(a.row_out), 64'h0D0C0B);
    check_eq("db_new_idx", 64'(a.row_idx), 64'd0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
               1'($urandom), 1'($urandom));
    end

    // K=4, 16-bit instance
    do_reset();
    for (int i = 0; i < KK2; i++) cyc_b(1'b1, 16'(16'h100 + i), 1'b0, 1'b0, 1'b0);
    cyc_b(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < K2; r++) cyc_b(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check_eq("k4_row3", b.row_out, 64'h010F_010E_010D_010C);
    check_eq("k4_idx3", 64'(b.row_idx), 64'd3);
    for (int i = 0; i < KK2; i++) cyc_b(1'b1, 16'(16'h100 + i), 1'b0, 1'b0, 1'b0);
    cyc_b(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    cyc_b(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check_eq("k4_flip_row0", b.row_out, 64'h010C_010D_010E_010F);
    check_eq("k4_flip_valid", 64'(b.row_valid), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
